// File: rtl/read_command_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// read_command_sequencer_pkg
// Shared types and default constants for the read command sequencer.
//   state_t        : sequencer FSM states
//   cmd_fields_t   : the {addr, tag} pair carried on the command outputs
//   DEF_*          : default geometry used as parameter defaults
// -----------------------------------------------------------------------------
package read_command_sequencer_pkg;

    localparam int CMD_ADDR_WIDTH      = 64;
    localparam int CMD_TAG_WIDTH       = 8;
    localparam int DEF_COUNT_WIDTH     = 32;
    localparam int DEF_CL_BYTES        = 128;
    localparam int DEF_MAX_OUTSTANDING = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [CMD_ADDR_WIDTH-1:0] addr;
        logic [CMD_TAG_WIDTH-1:0]  tag;
    } cmd_fields_t;

endpackage

// File: rtl/read_command_sequencer_tag_table.sv
// -----------------------------------------------------------------------------
// read_tag_table
// Outstanding-tag bookkeeping for the read command sequencer.
//   alloc_en/alloc_addr      : allocate the lowest free slot, remember its address
//   retry_take               : clear the lowest pending retry bit (re-issued)
//   rsp_valid/rsp_tag/rsp_done : response; DONE frees, not-DONE marks for retry
//   free_avail/free_idx      : lowest free slot (from registered bitmap)
//   retry_pending/retry_idx/retry_addr : lowest retry slot and its address
//   alloc_count              : number of allocated slots
//   rsp_done_hit             : a DONE response hit an allocated slot
//   rsp_error                : response to an unallocated or out-of-range tag
// -----------------------------------------------------------------------------
module read_tag_table #(
    parameter int SLOTS      = 16,
    parameter int ADDR_WIDTH = 64,
    parameter int TAG_WIDTH  = 8,
    parameter int SLOT_W     = (SLOTS > 1) ? $clog2(SLOTS) : 1,
    parameter int CNT_W      = SLOT_W + 1
) (
    input  logic                  clock,
    input  logic                  rstn,
    input  logic                  alloc_en,
    input  logic [ADDR_WIDTH-1:0] alloc_addr,
    input  logic                  retry_take,
    input  logic                  rsp_valid,
    input  logic [TAG_WIDTH-1:0]  rsp_tag,
    input  logic                  rsp_done,
    output logic                  free_avail,
    output logic [SLOT_W-1:0]     free_idx,
    output logic                  retry_pending,
    output logic [SLOT_W-1:0]     retry_idx,
    output logic [ADDR_WIDTH-1:0] retry_addr,
    output logic [CNT_W-1:0]      alloc_count,
    output logic                  rsp_done_hit,
    output logic                  rsp_error
);

    logic [SLOTS-1:0]      alloc_q;
    logic [SLOTS-1:0]      retry_q;
    logic [ADDR_WIDTH-1:0] addr_ram [SLOTS];

    logic [SLOT_W-1:0] rsp_slot;
    logic              rsp_in_range;
    logic              rsp_hit;
    logic [SLOTS-1:0]  free_mask;
    logic [SLOTS-1:0]  retry_set;
    logic [SLOTS-1:0]  retry_clr;
    logic [SLOTS-1:0]  alloc_set;

    // Lowest-index priority encoders: scanning downward leaves the lowest hit.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        free_avail    = 1'b0;
        free_idx      = '0;
        retry_pending = 1'b0;
        retry_idx     = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!alloc_q[i]) begin
                free_avail = 1'b1;
                free_idx   = SLOT_W'(i);
            end
            if (retry_q[i]) begin
                retry_pending = 1'b1;
                retry_idx     = SLOT_W'(i);
            end
        end
    end

    always_comb begin
        alloc_count = '0;
        for (int i = 0; i < SLOTS; i++) begin
            alloc_count = alloc_count + CNT_W'(alloc_q[i]);
        end
    end

    assign retry_addr = addr_ram[retry_idx];

    // Tags are compared at 32 bits so a full 2^TAG_WIDTH slot table cannot wrap.
    assign rsp_slot     = rsp_tag[SLOT_W-1:0];
    assign rsp_in_range = (32'(rsp_tag) < 32'(SLOTS));
    assign rsp_hit      = rsp_valid && rsp_in_range && alloc_q[rsp_slot];
    assign rsp_done_hit = rsp_hit && rsp_done;
    assign rsp_error    = rsp_valid && !(rsp_in_range && alloc_q[rsp_slot]);

    assign free_mask = rsp_done_hit             ? (SLOTS'(1) << rsp_slot)  : '0;
    assign retry_set = (rsp_hit && !rsp_done)   ? (SLOTS'(1) << rsp_slot)  : '0;
    assign retry_clr = retry_take               ? (SLOTS'(1) << retry_idx) : '0;
    assign alloc_set = alloc_en                 ? (SLOTS'(1) << free_idx)  : '0;

    // A same-cycle response wins over an issue: the retry clear is applied
    // first and a new retry request is OR-ed in after it.
    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            alloc_q <= '0;
            retry_q <= '0;
        end else begin
            alloc_q <= (alloc_q | alloc_set) & ~free_mask;
            retry_q <= ((retry_q & ~retry_clr) | retry_set) & ~free_mask;
        end
    end

    // NOTE: the address RAM is deliberately not reset; a slot is only read
    // after its allocation has written it.
    always_ff @(posedge clock) begin
        if (alloc_en) begin
            addr_ram[free_idx] <= alloc_addr;
        end
    end

endmodule

// File: rtl/read_command_sequencer.sv
// -----------------------------------------------------------------------------
// read_command_sequencer
// Turns one read job (base address + cache-line count) into a stream of
// cache-line read commands, tracks outstanding tags, re-issues failed lines
// and pulses job_done_out once every line has completed.
//   clock, rstn                         : clock, async active-low reset
//   enable_in                           : gate for new issues
//   job_valid_in/job_addr_in/job_lines_in, job_ready_out : job handshake
//   cmd_buffer_full_in                  : almost-full stall from command buffer
//   cmd_valid_out/cmd_addr_out/cmd_tag_out : registered command pulse
//   rsp_valid_in/rsp_tag_in/rsp_done_in : command responses
//   lines_done_out, busy_out, job_done_out, protocol_error_out : status
// -----------------------------------------------------------------------------
module read_command_sequencer
    import read_command_sequencer_pkg::*;
#(
    parameter int ADDR_WIDTH      = CMD_ADDR_WIDTH,
    parameter int COUNT_WIDTH     = DEF_COUNT_WIDTH,
    parameter int TAG_WIDTH       = CMD_TAG_WIDTH,
    parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
    parameter int CL_BYTES        = DEF_CL_BYTES
) (
    input  logic                   clock,
    input  logic                   rstn,
    input  logic                   enable_in,
    input  logic                   job_valid_in,
    input  logic [ADDR_WIDTH-1:0]  job_addr_in,
    input  logic [COUNT_WIDTH-1:0] job_lines_in,
    output logic                   job_ready_out,
    input  logic                   cmd_buffer_full_in,
    output logic                   cmd_valid_out,
    output logic [ADDR_WIDTH-1:0]  cmd_addr_out,
    output logic [TAG_WIDTH-1:0]   cmd_tag_out,
    input  logic                   rsp_valid_in,
    input  logic [TAG_WIDTH-1:0]   rsp_tag_in,
    input  logic                   rsp_done_in,
    output logic [COUNT_WIDTH-1:0] lines_done_out,
    output logic                   busy_out,
    output logic                   job_done_out,
    output logic                   protocol_error_out
);

    localparam int SLOT_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CNT_W  = SLOT_W + 1;
    localparam logic [ADDR_WIDTH-1:0] LINE_STEP = ADDR_WIDTH'(CL_BYTES);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(CL_BYTES - 1);

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] remaining_q;
    logic [ADDR_WIDTH-1:0]  next_addr_q;
    logic [COUNT_WIDTH-1:0] lines_done_q;
    cmd_fields_t            cmd_q, cmd_d;
    logic                   cmd_valid_q;
    logic                   job_done_q;
    logic                   protocol_error_q;

    logic                   accept;
    logic                   issue;
    logic                   alloc_en;
    logic                   retry_take;
    logic                   can_issue;

    logic                   free_avail;
    logic [SLOT_W-1:0]      free_idx;
    logic                   retry_pending;
    logic [SLOT_W-1:0]      retry_idx;
    logic [ADDR_WIDTH-1:0]  retry_addr;
    logic [CNT_W-1:0]       alloc_count;
    logic                   rsp_done_hit;
    logic                   rsp_error;

    read_tag_table #(
        .SLOTS      (MAX_OUTSTANDING),
        .ADDR_WIDTH (ADDR_WIDTH),
        .TAG_WIDTH  (TAG_WIDTH),
        .SLOT_W     (SLOT_W),
        .CNT_W      (CNT_W)
    ) u_tag_table (
        .clock         (clock),
        .rstn          (rstn),
        .alloc_en      (alloc_en),
        .alloc_addr    (next_addr_q),
        .retry_take    (retry_take),
        .rsp_valid     (rsp_valid_in),
        .rsp_tag       (rsp_tag_in),
        .rsp_done      (rsp_done_in),
        .free_avail    (free_avail),
        .free_idx      (free_idx),
        .retry_pending (retry_pending),
        .retry_idx     (retry_idx),
        .retry_addr    (retry_addr),
        .alloc_count   (alloc_count),
        .rsp_done_hit  (rsp_done_hit),
        .rsp_error     (rsp_error)
    );

    assign can_issue = enable_in && !cmd_buffer_full_in;

    // Next-state and issue decision. Retries always beat new lines; at most
    // one command is chosen per cycle and registered into cmd_q.
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        accept     = 1'b0;
        issue      = 1'b0;
        alloc_en   = 1'b0;
        retry_take = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (job_valid_in && enable_in) begin
                    accept  = 1'b1;
                    state_d = (job_lines_in == '0) ? ST_DONE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (can_issue) begin
                    if (retry_pending) begin
                        retry_take = 1'b1;
                        issue      = 1'b1;
                        cmd_d.addr = retry_addr;
                        cmd_d.tag  = TAG_WIDTH'(retry_idx);
                    end else if (free_avail) begin
                        alloc_en   = 1'b1;
                        issue      = 1'b1;
                        cmd_d.addr = next_addr_q;
                        cmd_d.tag  = TAG_WIDTH'(free_idx);
                        if (remaining_q == COUNT_WIDTH'(1)) begin
                            state_d = ST_DRAIN;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (can_issue && retry_pending) begin
                    retry_take = 1'b1;
                    issue      = 1'b1;
                    cmd_d.addr = retry_addr;
                    cmd_d.tag  = TAG_WIDTH'(retry_idx);
                end else if (!retry_pending && alloc_count == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_q          <= ST_IDLE;
            remaining_q      <= '0;
            next_addr_q      <= '0;
            lines_done_q     <= '0;
            cmd_q            <= '0;
            cmd_valid_q      <= 1'b0;
            job_done_q       <= 1'b0;
            protocol_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= issue;
            job_done_q  <= (state_q == ST_DONE);

            if (accept) begin
                next_addr_q <= job_addr_in & LINE_MASK;
                remaining_q <= job_lines_in;
            end else if (alloc_en) begin
                next_addr_q <= next_addr_q + LINE_STEP;
                remaining_q <= remaining_q - COUNT_WIDTH'(1);
            end

            if (accept) begin
                lines_done_q <= '0;
            end else if (rsp_done_hit) begin
                lines_done_q <= lines_done_q + COUNT_WIDTH'(1);
            end

            if (rsp_error) begin
                protocol_error_q <= 1'b1;
            end
        end
    end

    assign job_ready_out      = (state_q == ST_IDLE);
    assign busy_out           = (state_q != ST_IDLE);
    assign cmd_valid_out      = cmd_valid_q;
    assign cmd_addr_out       = cmd_q.addr;
    assign cmd_tag_out        = cmd_q.tag;
    assign lines_done_out     = lines_done_q;
    assign job_done_out       = job_done_q;
    assign protocol_error_out = protocol_error_q;

endmodule
